instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction word width (multiple of 8).
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning word count (power of 2); ADDR_W = log2(DEPTH).
REQ-003 The block SHALL have parameter NOP_WORD, default 0, meaning the word returned on a fetch fault.
REQ-004 The block SHALL have the following ports, one per line, with one clock, i_clk, and synchronous active-low reset i_rst_n:
  i_clk  in  1  clock; all logic on its rising edge
  i_rst_n  in  1  synchronous active-low reset
  i_fetch_req  in  1  fetch request
  i_address  in  32  byte address of the fetch
  o_instruction  out  DATA_W  fetched word
  o_fetch_valid  out  1  o_instruction valid this cycle
  o_fetch_fault  out  1  fetch address misaligned or out of range
  i_load_start  in  1  begin program load
  i_load_byte_valid  in  1  i_load_byte valid
  i_load_byte  in  8  load byte, MSB-first within each word
  i_load_last  in  1  final byte of the image (qualified by valid)
  o_load_busy  out  1  high in CLEAR or LOAD
  o_load_done  out  1  one-cycle pulse at load completion
  o_load_overflow  out  1  sticky: image exceeded DEPTH words
  o_load_words  out  ADDR_W+1  words written by the last or current load

Function
REQ-005 The block SHALL have FSM states CLEAR, READY and LOAD.
REQ-006 In CLEAR, one word per cycle SHALL be written to 0 from index 0 to DEPTH-1, then the FSM SHALL enter READY; CLEAR takes exactly DEPTH cycles.
REQ-007 In READY, i_load_start SHALL enter LOAD next cycle, with load pointer, byte counter, o_load_words and o_load_overflow cleared.
REQ-008 In LOAD, each valid byte SHALL shift into a word assembler; the first byte lands in bits [DATA_W-1:DATA_W-8].
REQ-009 On the DATA_W/8-th byte, the word SHALL be written at the load pointer, and the pointer and o_load_words SHALL increment.
REQ-010 A valid byte with i_load_last SHALL write the current word, zero-padded in the unfilled low bytes, pulse o_load_done and return to READY next cycle.
REQ-011 If i_load_last arrives on a word boundary, no extra word SHALL be written.
REQ-012 Writes at pointer >= DEPTH SHALL be dropped, o_load_overflow SHALL be set, and o_load_words SHALL saturate at DEPTH.
REQ-013 Words not rewritten by a load SHALL keep their prior contents.
REQ-014 i_load_start outside READY, and i_load_byte_valid outside LOAD, SHALL be ignored.
REQ-015 A fetch SHALL have 1-cycle latency: with i_fetch_req=1 in READY at edge N, o_fetch_valid=1 and o_instruction SHALL appear after edge N+1.
REQ-016 The word index SHALL be i_address[ADDR_W+1:2].
REQ-017 A fault SHALL be flagged when i_address[1:0]!=0 or i_address[31:ADDR_W+2]!=0; on a fault, o_instruction SHALL be NOP_WORD and o_fetch_fault=1, both with o_fetch_valid.
REQ-018 A fetch in CLEAR or LOAD SHALL be stalled: o_fetch_valid=0 next cycle, and the request SHALL NOT be queued.
REQ-019 When no valid fetch completes, o_instruction SHALL hold its last value and o_fetch_valid/o_fetch_fault SHALL be 0.
REQ-020 i_fetch_req and i_load_start in the same READY cycle SHALL both take effect: the fetch returns pre-load contents, then LOAD begins.
REQ-021 o_load_busy SHALL be combinational from state: 1 in CLEAR/LOAD, 0 in READY.

Reset
REQ-022 While i_rst_n=0 at a clock edge, the block SHALL enter CLEAR with pointer 0, and o_instruction, o_fetch_valid, o_fetch_fault, o_load_done, o_load_overflow and o_load_words all 0.
REQ-023 Reset asserted mid-LOAD or mid-CLEAR SHALL abort the operation and restart CLEAR; the memory is fully re-zeroed.

Verification
REQ-024 Reset, then wait: o_load_busy=1 for exactly 512 cycles; then fetching 0x000 and 0x7FC returns 0 with valid=1, fault=0.
REQ-025 Load bytes 20,10,00,00,20,05,00,00 (last on 8th): o_load_done pulses, o_load_words=2; fetch 0x0 -> 0x20100000, fetch 0x4 -> 0x20050000, one cycle after each request.
REQ-026 Load 5 bytes 8C,A8,00,00,20 with last: word1 = 0x20000000, o_load_words=2.
REQ-027 Fetch 0x2 -> fault=1, o_instruction=NOP_WORD; fetch 0x800 -> fault=1; a fetch during LOAD -> o_fetch_valid=0.
REQ-028 Load 2052 bytes (DEPTH=512): o_load_overflow=1, o_load_words=512, and word 0 is unchanged by the excess bytes.
REQ-029 Assert reset after 3 load bytes: CLEAR restarts, and after 512 cycles every fetched word is 0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction memory with byte-stream program loader and 1-cycle fetch port
module instr_mem_loader #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 512,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_fetch_req,
  input  logic [31:0]                   i_address,
  output logic [DATA_W-1:0]             o_instruction,
  output logic                          o_fetch_valid,
  output logic                          o_fetch_fault,
  input  logic                          i_load_start,
  input  logic                          i_load_byte_valid,
  input  logic [7:0]                    i_load_byte,
  input  logic                          i_load_last,
  output logic                          o_load_busy,
  output logic                          o_load_done,
  output logic                          o_load_overflow,
  output logic [$clog2(DEPTH):0]        o_load_words
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BYTES  = DATA_W / 8;
  localparam int BC_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {CLEAR, READY, LOAD} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   clr_idx;
  logic [ADDR_W:0]     load_ptr;
  logic [BC_W-1:0]     byte_cnt;
  logic [DATA_W-1:0]   asm_word;
  logic [DATA_W-1:0]   fill_word;
  logic                byte_take;
  logic                word_done;
  logic                ptr_in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   fetch_idx;
  logic [31:0]         addr_hi;
  logic                fetch_bad;
  logic                fetch_go;

  assign byte_take    = (state == LOAD) && i_load_byte_valid;
  assign word_done    = byte_take && (i_load_last || (byte_cnt == BC_W'(BYTES - 1)));
  assign ptr_in_range = load_ptr < (ADDR_W + 1)'(DEPTH);

  assign fetch_idx = i_address[ADDR_W+1:2];
  assign addr_hi   = i_address >> (ADDR_W + 2);
  assign fetch_bad = (i_address[1:0] != 2'b00) || (addr_hi != 32'd0);
  assign fetch_go  = i_fetch_req && (state == READY);

  assign o_load_busy  = (state != READY);
  assign o_load_words = load_ptr;

  // Unfilled low bytes of asm_word are still zero, which gives the padding on a short final word
  always_comb begin
    fill_word = asm_word;
    for (int b = 0; b < BYTES; b++) begin
      if (byte_cnt == BC_W'(b)) begin
        fill_word[DATA_W-1-8*b -: 8] = i_load_byte;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (clr_idx == ADDR_W'(DEPTH - 1)) state_nxt = READY;
      READY: if (i_load_start) state_nxt = LOAD;
      LOAD:  if (byte_take && i_load_last) state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_idx;
    mem_wdata = '0;
    if (state == CLEAR && i_rst_n) begin
      mem_we = 1'b1;
    end else if (word_done && ptr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = load_ptr[ADDR_W-1:0];
      mem_wdata = fill_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clr_idx         <= '0;
      load_ptr        <= '0;
      byte_cnt        <= '0;
      asm_word        <= '0;
      o_load_overflow <= 1'b0;
      o_load_done     <= 1'b0;
      o_fetch_valid   <= 1'b0;
      o_fetch_fault   <= 1'b0;
      o_instruction   <= '0;
    end else begin
      o_load_done <= 1'b0;
      case (state)
        CLEAR: clr_idx <= clr_idx + 1'b1;
        READY: begin
          if (i_load_start) begin
            load_ptr        <= '0;
            byte_cnt        <= '0;
            asm_word        <= '0;
            o_load_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (byte_take) begin
            if (word_done) begin
              asm_word <= '0;
              byte_cnt <= '0;
              // load_ptr stops at DEPTH, so it doubles as the saturating word count
              if (ptr_in_range) begin
                load_ptr <= load_ptr + 1'b1;
              end else begin
                o_load_overflow <= 1'b1;
              end
              o_load_done <= i_load_last;
            end else begin
              asm_word <= fill_word;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase

      o_fetch_valid <= fetch_go;
      o_fetch_fault <= fetch_go && fetch_bad;
      if (fetch_go) begin
        o_instruction <= fetch_bad ? NOP_WORD : mem[fetch_idx];
      end
    end
  end

endmodule
